// File: rtl/pulse_width_meter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pulse_width_meter_pkg
//  Description : Shared types and constants for the pulse width meter:
//                measurement state encoding, default widths and the
//                saturation-value helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package pulse_width_meter_pkg;

  localparam int W_DEFAULT           = 10;
  localparam int SYNC_STAGES_DEFAULT = 2;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    MEAS_HIGH = 2'd1,
    MEAS_LOW  = 2'd2
  } state_e;

  // Largest value a w-bit counter can hold; widths clamp here.
  function automatic logic [31:0] sat_max(input int w);
    return (32'd1 << w) - 32'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pulse_width_meter_edge_sync.sv
`default_nettype none
// ============================================================================
//  Module      : pulse_width_meter_edge_sync
//  Description : Multi-flop synchroniser for the measured signal, one-cycle
//                delayed copy and rise/fall detection. Also flags when the
//                delayed copy holds a genuine post-reset sample, so that the
//                reset value of the pipeline is never mistaken for an edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module pulse_width_meter_edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic sys_clk,
  input  logic sys_rst,
  input  logic sig_in,
  output logic s,
  output logic rise,
  output logic fall,
  output logic primed
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   sdly_q, sdly_d;
  // One marker bit per pipeline stage (synchroniser + delay flop); the top
  // bit is set once the delay flop holds a real sample of sig_in.
  logic [SYNC_STAGES:0]   prime_q, prime_d;

  // Next-state for the synchroniser chain, delay flop and priming marker.
  always_comb begin
    sync_d  = {sync_q[SYNC_STAGES-2:0], sig_in};
    sdly_d  = sync_q[SYNC_STAGES-1];
    prime_d = {prime_q[SYNC_STAGES-1:0], 1'b1};
  end

  // Pipeline registers, all cleared by reset.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      sync_q  <= '0;
      sdly_q  <= 1'b0;
      prime_q <= '0;
    end else begin
      sync_q  <= sync_d;
      sdly_q  <= sdly_d;
      prime_q <= prime_d;
    end
  end

  assign s      = sync_q[SYNC_STAGES-1];
  assign rise   = s & ~sdly_q;
  assign fall   = ~s & sdly_q;
  assign primed = prime_q[SYNC_STAGES];

endmodule
`default_nettype wire

// File: rtl/pulse_width_meter.sv
`default_nettype none
// ============================================================================
//  Module      : pulse_width_meter
//  Description : Measures high time, low time and period of an asynchronous
//                square wave in sys_clk cycles. One result per complete
//                period (rise to rise), flagged by a one-cycle strobe. Counts
//                saturate at 2^W-1; sat qualifies a result, stuck reports a
//                phase that is currently saturated.
//  Revision    : 1.0 - initial release
// ============================================================================
module pulse_width_meter
  import pulse_width_meter_pkg::*;
#(
  parameter int W           = W_DEFAULT,
  parameter int SYNC_STAGES = SYNC_STAGES_DEFAULT
) (
  input  logic         sys_clk,
  input  logic         sys_rst,
  input  logic         sig_in,
  output logic [W-1:0] high_width,
  output logic [W-1:0] low_width,
  output logic [W:0]   period,
  output logic         meas_valid,
  output logic         sat,
  output logic         stuck
);

  localparam logic [W-1:0] C_MAX = W'(sat_max(W));
  localparam logic [W-1:0] C_ONE = W'(1);

  logic s, rise, fall, primed;

  pulse_width_meter_edge_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_edge_sync (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .sig_in  (sig_in),
    .s       (s),
    .rise    (rise),
    .fall    (fall),
    .primed  (primed)
  );

  state_e       state_q, state_d;
  logic [W-1:0] cnt_q, cnt_d;
  logic [W-1:0] cnt_inc;
  logic [W-1:0] hi_tmp_q, hi_tmp_d;
  logic [W-1:0] high_width_q, high_width_d;
  logic [W-1:0] low_width_q, low_width_d;
  logic [W:0]   period_q, period_d;
  logic         meas_valid_q, meas_valid_d;
  logic         sat_q, sat_d;
  logic         stuck_q, stuck_d;

  // Measurement FSM: phase tracking, saturating counter and result capture.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    hi_tmp_d     = hi_tmp_q;
    high_width_d = high_width_q;
    low_width_d  = low_width_q;
    period_d     = period_q;
    meas_valid_d = 1'b0;
    sat_d        = sat_q;
    cnt_inc      = (cnt_q == C_MAX) ? cnt_q : cnt_q + C_ONE;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        // Until the edge pipeline holds real samples, an apparent rise is
        // just the reset value draining out; a signal that was already high
        // at reset must not start a measurement.
        if (rise && primed) begin
          state_d = MEAS_HIGH;
          cnt_d   = C_ONE;
        end
      end
      MEAS_HIGH: begin
        if (fall) begin
          hi_tmp_d = cnt_q;
          cnt_d    = C_ONE;
          state_d  = MEAS_LOW;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      MEAS_LOW: begin
        if (rise) begin
          high_width_d = hi_tmp_q;
          low_width_d  = cnt_q;
          period_d     = {1'b0, hi_tmp_q} + {1'b0, cnt_q};
          sat_d        = (hi_tmp_q == C_MAX) || (cnt_q == C_MAX);
          meas_valid_d = 1'b1;
          cnt_d        = C_ONE;
          state_d      = MEAS_HIGH;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    // Registered alongside the counter so it tracks the counter exactly.
    stuck_d = (state_d != IDLE) && (cnt_d == C_MAX);
  end

  // State, counter and output registers; reset aborts any measurement.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      hi_tmp_q     <= '0;
      high_width_q <= '0;
      low_width_q  <= '0;
      period_q     <= '0;
      meas_valid_q <= 1'b0;
      sat_q        <= 1'b0;
      stuck_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      hi_tmp_q     <= hi_tmp_d;
      high_width_q <= high_width_d;
      low_width_q  <= low_width_d;
      period_q     <= period_d;
      meas_valid_q <= meas_valid_d;
      sat_q        <= sat_d;
      stuck_q      <= stuck_d;
    end
  end

  assign high_width = high_width_q;
  assign low_width  = low_width_q;
  assign period     = period_q;
  assign meas_valid = meas_valid_q;
  assign sat        = sat_q;
  assign stuck      = stuck_q;

endmodule
`default_nettype wire
